// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings and the helper that extracts a
// flit's type field.
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_TAIL = 2'b00,
    FLIT_BODY = 2'b01,
    FLIT_HEAD = 2'b10,
    FLIT_IDLE = 2'b11
  } flit_type_e;

  localparam int unsigned FLIT_MAX_W = 128;

  // Flit type sits in the two MSBs of a flit_w-wide flit (zero-extended on entry).
  function automatic flit_type_e flit_type(input logic [FLIT_MAX_W-1:0] flit,
                                           input int unsigned           flit_w);
    return flit_type_e'(flit[flit_w-1 -: 2]);
  endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Show-ahead flit FIFO for one virtual channel; push ignored when full, pop
// ignored when empty.
module noc_vc_fifo #(
  parameter int unsigned FLIT_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [FLIT_W-1:0]      din,
  output logic [FLIT_W-1:0]      dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/noc_vc_out_port.sv
// Router output port: per-VC flit FIFOs, round-robin VC arbitration with
// wormhole locking, link handshake and sticky protocol-error detection.
module noc_vc_out_port
  import noc_pkg::*;
#(
  parameter  int unsigned FLIT_W = 16,
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned NUM_VC = 2,
  localparam int unsigned VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [VC_W-1:0]         in_vc,
  input  logic [FLIT_W-1:0]       in_flit,
  output logic [NUM_VC-1:0]       in_ready,
  output logic [NUM_VC*CNT_W-1:0] occupancy,
  input  logic [NUM_VC-1:0]       alloc,
  output logic [NUM_VC-1:0]       alloc_status,
  output logic                    write_req,
  input  logic                    write_req_ack,
  output logic [FLIT_W-1:0]       out_flit,
  output logic [VC_W-1:0]         out_vc,
  output logic                    proto_err
);

  logic [FLIT_W-1:0] front [NUM_VC];
  logic [CNT_W-1:0]  cnt   [NUM_VC];
  flit_type_e        ftype [NUM_VC];
  logic [NUM_VC-1:0] full, empty, push, pop, elig, discard;
  flit_type_e        in_type, gtype;

  logic              lock_q, hold_q, proto_err_q;
  logic [VC_W-1:0]   lock_vc_q, hold_vc_q, rr_q, rr_d;
  logic [NUM_VC-1:0] alloc_status_q;
  logic              grant_valid, fire;
  logic [VC_W-1:0]   grant_vc, idx_vc;

  assign in_type = flit_type(FLIT_MAX_W'(in_flit), FLIT_W);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    noc_vc_fifo #(
      .FLIT_W(FLIT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push[v]),
      .pop  (pop[v]),
      .din  (in_flit),
      .dout (front[v]),
      .count(cnt[v]),
      .full (full[v]),
      .empty(empty[v])
    );
    assign ftype[v]                    = flit_type(FLIT_MAX_W'(front[v]), FLIT_W);
    assign push[v]                     = in_valid && (in_vc == VC_W'(v)) && !full[v] &&
                                         (in_type != FLIT_IDLE);
    assign in_ready[v]                 = !full[v];
    assign occupancy[v*CNT_W +: CNT_W] = cnt[v];
  end

  // Misplaced fronts (BODY/TAIL outside the lock, HEAD inside it) are discarded, never sent.
  always_comb begin
    elig    = '0;
    discard = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (lock_q && (lock_vc_q == VC_W'(v))) begin
        elig[v]    = !empty[v] && alloc_status_q[v] && (ftype[v] != FLIT_HEAD);
        discard[v] = !empty[v] && (ftype[v] == FLIT_HEAD);
      end else begin
        elig[v]    = !lock_q && !empty[v] && alloc_status_q[v] && (ftype[v] == FLIT_HEAD);
        discard[v] = !empty[v] && (ftype[v] != FLIT_HEAD);
      end
    end
  end

  // An offered but unacked grant is held so out_flit cannot switch to a newly eligible VC.
  always_comb begin
    grant_valid = 1'b0;
    grant_vc    = '0;
    idx_vc      = '0;
    if (hold_q && elig[hold_vc_q]) begin
      grant_valid = 1'b1;
      grant_vc    = hold_vc_q;
    end else begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        idx_vc = VC_W'((32'(rr_q) + i) % NUM_VC);
        if (!grant_valid && elig[idx_vc]) begin
          grant_valid = 1'b1;
          grant_vc    = idx_vc;
        end
      end
    end
  end

  assign write_req = grant_valid && !reset;
  assign fire      = write_req && write_req_ack;
  assign out_flit  = write_req ? front[grant_vc] : '1;
  assign out_vc    = write_req ? grant_vc : '0;
  assign gtype     = ftype[grant_vc];
  assign rr_d      = (grant_vc == VC_W'(NUM_VC - 1)) ? '0 : grant_vc + VC_W'(1);

  always_comb begin
    pop = discard;
    if (fire) pop[grant_vc] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q         <= 1'b0;
      lock_vc_q      <= '0;
      hold_q         <= 1'b0;
      hold_vc_q      <= '0;
      rr_q           <= '0;
      proto_err_q    <= 1'b0;
      alloc_status_q <= '0;
    end else begin
      alloc_status_q <= alloc;
      hold_q         <= write_req && !write_req_ack;
      hold_vc_q      <= grant_vc;
      if (|discard) proto_err_q <= 1'b1;
      if (fire) begin
        if (gtype == FLIT_HEAD) begin
          lock_q    <= 1'b1;
          lock_vc_q <= grant_vc;
        end else if (gtype == FLIT_TAIL) begin
          lock_q <= 1'b0;
          rr_q   <= rr_d;
        end
      end
    end
  end

  assign alloc_status = alloc_status_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_noc_vc_out_port.sv
// Directed bench for noc_vc_out_port: scoreboard of expected link flits plus
// state checks on occupancy, ready, lock stalls and protocol errors.
`timescale 1ns/1ps
module tb_noc_vc_out_port;

  localparam int unsigned FLIT_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NUM_VC = 2;
  localparam int unsigned VC_W   = 1;
  localparam int unsigned CNT_W  = 3;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_valid = 1'b0;
  logic [VC_W-1:0]         in_vc = '0;
  logic [FLIT_W-1:0]       in_flit = '0;
  logic [NUM_VC-1:0]       in_ready;
  logic [NUM_VC*CNT_W-1:0] occupancy;
  logic [NUM_VC-1:0]       alloc = '0;
  logic [NUM_VC-1:0]       alloc_status;
  logic                    write_req;
  logic                    write_req_ack = 1'b0;
  logic [FLIT_W-1:0]       out_flit;
  logic [VC_W-1:0]         out_vc;
  logic                    proto_err;

  noc_vc_out_port #(
    .FLIT_W(FLIT_W),
    .DEPTH (DEPTH),
    .NUM_VC(NUM_VC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .in_flit      (in_flit),
    .in_ready     (in_ready),
    .occupancy    (occupancy),
    .alloc        (alloc),
    .alloc_status (alloc_status),
    .write_req    (write_req),
    .write_req_ack(write_req_ack),
    .out_flit     (out_flit),
    .out_vc       (out_vc),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VC_W-1:0]   vc;
    logic [FLIT_W-1:0] flit;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_out(input logic [VC_W-1:0] vc, input logic [FLIT_W-1:0] f);
    exp_t e;
    e.vc   = vc;
    e.flit = f;
    sb.push_back(e);
  endtask

  // One clock: inputs were set at the preceding negedge; any handshake due at
  // the coming posedge is scored against the queue head.
  task automatic cycle();
    exp_t e;
    #1;
    if (write_req && write_req_ack) begin
      n_checks++;
      assert (sb.size() != 0) n_pass++;
      else $error("FAIL spurious_send: observed flit 0x%0h vc %0d expected no send",
                  out_flit, out_vc);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_flit", 32'(out_flit), 32'(e.flit));
        check("out_vc", 32'(out_vc), 32'(e.vc));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [VC_W-1:0] vc, input logic [FLIT_W-1:0] f);
    in_valid = 1'b1;
    in_vc    = vc;
    in_flit  = f;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) cycle();
    n_checks++;
    assert (sb.size() == 0) n_pass++;
    else $error("FAIL %s: observed %0d undelivered flits expected 0", tag, sb.size());
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_write_req", 32'(write_req), 32'd0);
    check("rst_out_flit", 32'(out_flit), 32'hFFFF);
    check("rst_out_vc", 32'(out_vc), 32'd0);
    cycle();
    reset = 1'b0;
    cycle();
    check("init_in_ready", 32'(in_ready), 32'h3);
    check("init_occupancy", 32'(occupancy), 32'h0);
    check("init_proto_err", 32'(proto_err), 32'd0);
    check("init_write_req", 32'(write_req), 32'd0);
    check("init_alloc_status", 32'(alloc_status), 32'd0);

    // Single packet on VC0 with ack held high
    alloc = 2'b01;
    write_req_ack = 1'b1;
    cycle();
    check("alloc_status_delay", 32'(alloc_status), 32'h1);
    expect_out(1'b0, 16'h8001);
    expect_out(1'b0, 16'h4002);
    expect_out(1'b0, 16'h0003);
    push(1'b0, 16'h8001);
    push(1'b0, 16'h4002);
    push(1'b0, 16'h0003);
    check("back_to_back_req", 32'(write_req), 32'd1);
    drain("drain_pkt_vc0");
    check("pkt_vc0_occupancy", 32'(occupancy), 32'h0);

    // Fill VC1 without ack; refused pushes and push/pop on one VC
    alloc = 2'b10;
    write_req_ack = 1'b0;
    cycle();
    expect_out(1'b1, 16'h8011);
    expect_out(1'b1, 16'h4012);
    expect_out(1'b1, 16'h4013);
    expect_out(1'b1, 16'h0014);
    expect_out(1'b1, 16'h8016);
    expect_out(1'b1, 16'h0017);
    push(1'b1, 16'h8011);
    push(1'b1, 16'h4012);
    push(1'b1, 16'h4013);
    push(1'b1, 16'h0014);
    check("full_in_ready", 32'(in_ready), 32'h1);
    check("full_occupancy", 32'(occupancy), 32'h20);
    check("full_out_flit", 32'(out_flit), 32'h8011);
    push(1'b1, 16'h4015);
    check("refused_occupancy", 32'(occupancy), 32'h20);
    check("unacked_hold_req", 32'(write_req), 32'd1);
    check("unacked_hold_flit", 32'(out_flit), 32'h8011);
    write_req_ack = 1'b1;
    push(1'b1, 16'h4015);
    check("full_push_pop_refused", 32'(occupancy), 32'h18);
    push(1'b1, 16'h8016);
    check("push_pop_same_cycle", 32'(occupancy), 32'h18);
    push(1'b1, 16'h0017);
    check("push_pop_same_cycle2", 32'(occupancy), 32'h18);
    drain("drain_vc1_full");
    check("vc1_empty", 32'(occupancy), 32'h0);

    // Both VCs loaded: packets never interleave
    write_req_ack = 1'b0;
    alloc = 2'b11;
    cycle();
    expect_out(1'b0, 16'h8021);
    expect_out(1'b0, 16'h4022);
    expect_out(1'b0, 16'h0023);
    expect_out(1'b1, 16'h8031);
    expect_out(1'b1, 16'h4032);
    expect_out(1'b1, 16'h0033);
    push(1'b0, 16'h8021);
    push(1'b0, 16'h4022);
    push(1'b0, 16'h0023);
    push(1'b1, 16'h8031);
    push(1'b1, 16'h4032);
    push(1'b1, 16'h0033);
    check("both_loaded_occ", 32'(occupancy), 32'h1B);
    check("both_loaded_vc", 32'(out_vc), 32'd0);
    write_req_ack = 1'b1;
    drain("drain_two_pkts");

    // Two packets on VC0, one on VC1: VC1 gets its turn between them
    write_req_ack = 1'b0;
    expect_out(1'b0, 16'h8041);
    expect_out(1'b0, 16'h0042);
    expect_out(1'b1, 16'h8051);
    expect_out(1'b1, 16'h4052);
    expect_out(1'b1, 16'h0053);
    expect_out(1'b0, 16'h8043);
    expect_out(1'b0, 16'h0044);
    push(1'b0, 16'h8041);
    push(1'b0, 16'h0042);
    push(1'b0, 16'h8043);
    push(1'b0, 16'h0044);
    push(1'b1, 16'h8051);
    push(1'b1, 16'h4052);
    push(1'b1, 16'h0053);
    check("rr_loaded_occ", 32'(occupancy), 32'h1C);
    write_req_ack = 1'b1;
    drain("drain_rr");

    // Lock held across an empty VC0 while VC1 waits with a HEAD
    expect_out(1'b0, 16'h8061);
    expect_out(1'b0, 16'h4062);
    expect_out(1'b0, 16'h0063);
    expect_out(1'b1, 16'h8071);
    expect_out(1'b1, 16'h0072);
    push(1'b0, 16'h8061);
    push(1'b0, 16'h4062);
    push(1'b1, 16'h8071);
    check("lock_wait_req", 32'(write_req), 32'd0);
    cycle();
    check("lock_wait_req2", 32'(write_req), 32'd0);
    check("lock_wait_occ", 32'(occupancy), 32'h08);
    push(1'b0, 16'h0063);
    push(1'b1, 16'h0072);
    drain("drain_lock");

    // BODY without a HEAD is discarded and flags an error; IDLE is dropped
    push(1'b0, 16'h4005);
    check("orphan_no_req", 32'(write_req), 32'd0);
    cycle();
    check("orphan_discarded", 32'(occupancy), 32'h0);
    check("orphan_proto_err", 32'(proto_err), 32'd1);
    push(1'b1, 16'hC00F);
    check("idle_dropped", 32'(occupancy), 32'h0);
    repeat (3) cycle();
    check("proto_err_sticky", 32'(proto_err), 32'd1);
    expect_out(1'b1, 16'h8091);
    expect_out(1'b1, 16'h0092);
    push(1'b1, 16'h8091);
    push(1'b1, 16'h0092);
    drain("drain_after_err");
    check("proto_err_sticky2", 32'(proto_err), 32'd1);

    // Reset with a flit pending discards it and clears the error
    write_req_ack = 1'b0;
    alloc = 2'b01;
    cycle();
    push(1'b0, 16'h80A1);
    check("pre_reset_req", 32'(write_req), 32'd1);
    reset = 1'b1;
    #1;
    check("in_reset_write_req", 32'(write_req), 32'd0);
    check("in_reset_out_flit", 32'(out_flit), 32'hFFFF);
    check("in_reset_out_vc", 32'(out_vc), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("in_reset_alloc_status", 32'(alloc_status), 32'd0);
    reset = 1'b0;
    cycle();
    check("post_reset_occ", 32'(occupancy), 32'h0);
    check("post_reset_err", 32'(proto_err), 32'd0);
    check("post_reset_req", 32'(write_req), 32'd0);
    write_req_ack = 1'b1;
    expect_out(1'b0, 16'h80B1);
    expect_out(1'b0, 16'h00B2);
    push(1'b0, 16'h80B1);
    push(1'b0, 16'h00B2);
    drain("drain_post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
